snow3g_ks_ctrl: RTL and testbench
=================================

Name: snow3g_ks_ctrl

Overview:
- Sequencing controller for the SNOW 3G keystream datapath (LFSR + FSM, whose FSM update uses the S1/S2 32-bit S-boxes).
- Issues the key/IV load, 32 initialisation-mode clockings, and the single discarded keystream-mode clocking.
- Then runs N keystream clockings, presenting each 32-bit word z on a valid/ready output.
- Owns step timing so the clocked S-box (MULx) latency is respected.

Parameters:
- INIT_ROUNDS, 32: initialisation-mode clockings after load.
- STEP_LAT, 1: cycles from a step pulse until datapath outputs (z) are settled; legal range 1..15.
- CNT_W, 16: width of the word-count input and the remaining-word counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a session; sampled only in IDLE.
- len_words  in  CNT_W  number of keystream words to produce; latched with start.
- ks_word_in  in  32  keystream word z from the datapath.
- ks_ready  in  1  consumer accepts ks_word.
- key_load  out  1  one-cycle pulse that loads K/IV into the LFSR.
- fsm_clr  out  1  one-cycle pulse that clears R1/R2/R3; coincident with key_load.
- step  out  1  one-cycle pulse that clocks the LFSR and FSM once.
- init_mode  out  1  qualifies step; 1 means the F output is fed back into the LFSR.
- ks_word  out  32  registered keystream word.
- ks_valid  out  1  ks_word valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at session end.

Behaviour:
- Reset: rst high at an edge forces IDLE. All outputs are 0, including ks_word. Counters clear. This applies mid-session too; a pending ks_valid is dropped without handshake.
- States: IDLE, LOAD, INIT, DISC, GEN, SETTLE, OUT, DONE.
- IDLE:
  - start=1 latches len_words into rem_cnt and moves to LOAD.
  - start in any other state is ignored.
- LOAD: exactly one cycle with key_load=1 and fsm_clr=1; then INIT.
- INIT:
  - step=1 and init_mode=1 on the first cycle of each STEP_LAT-cycle slot. lat_cnt counts 0..STEP_LAT-1 and step fires at lat_cnt=0.
  - A round counter counts INIT_ROUNDS steps, so INIT lasts INIT_ROUNDS*STEP_LAT cycles.
  - Then DISC.
- DISC:
  - One slot of STEP_LAT cycles, with step=1 and init_mode=0 in its first cycle. The z value is not captured.
  - Goes to DONE if rem_cnt=0, else GEN.
- GEN: one cycle, step=1 and init_mode=0; then SETTLE.
- SETTLE:
  - Lasts STEP_LAT cycles.
  - On the last SETTLE cycle, ks_word<=ks_word_in at the edge and ks_valid rises the next cycle; then OUT.
- OUT:
  - ks_valid=1; ks_word is held stable until handshake.
  - On handshake (ks_valid & ks_ready): rem_cnt decrements. Next state is DONE if rem_cnt was 1, else GEN. ks_valid drops the cycle after handshake.
- DONE: done=1 for one cycle, busy=1; then IDLE (busy=0).
- init_mode is 0 whenever step=0.
- key_load and step are never high together.
- Throughput: one word per STEP_LAT+2 cycles when ks_ready is held high.
- len_words=0: full LOAD/INIT/DISC sequence, no ks_valid, then DONE.
- len_words=2^CNT_W-1: must complete without counter wrap.
- ks_ready high outside OUT has no effect.
- start asserted in the same cycle as DONE is ignored; it is accepted only once IDLE is reached.

Decomposition:
- Shared package snow3g_pkg holds:
  - the state enum typedef;
  - INIT_ROUNDS_DEF=32;
  - the KS_WORD_W=32 constant.
- Sub-module snow3g_step_timer: lat_cnt with load/expire and parameter STEP_LAT. It is reused by INIT, DISC and SETTLE.

Test Plan:
- Basic run (STEP_LAT=1, ks_ready=1): start=1 in cycle 0 with len_words=2 produces:
  - key_load/fsm_clr in cycle 1;
  - step with init_mode=1 in cycles 2–33 (32 pulses);
  - step with init_mode=0 in cycle 34;
  - GEN steps in cycles 35 and 38;
  - ks_valid in cycles 37 and 40, with ks_word equal to the ks_word_in value sampled in cycles 36 and 39;
  - done in cycle 41 and busy=0 in cycle 42.
- Backpressure: ks_ready=0 for 5 cycles during OUT keeps ks_valid=1 and ks_word constant, and no step occurs. rem_cnt decrements only once on the handshake.
- Zero length: len_words=0 gives 33 step pulses, zero ks_valid cycles, and done in cycle 35.
- STEP_LAT=3: the INIT step pulses are spaced 3 cycles apart (96 INIT cycles). ks_word captures the ks_word_in value present 3 cycles after each GEN step.
- Reset mid-INIT: rst at cycle 10 brings all outputs to 0 at cycle 11 and the state to IDLE. A new start is then fully re-sequenced, including key_load.
- Start while busy: a start pulse during GEN is ignored, and the session still produces exactly len_words words.

Source files
------------

// File: rtl/snow3g_pkg.sv
// ---------------------------------------------------------------------------
// snow3g_pkg
// Shared definitions for the SNOW 3G keystream sequencing controller.
//   ks_state_e      : controller state encoding
//   INIT_ROUNDS_DEF : default number of initialisation-mode clockings
//   KS_WORD_W       : width of a keystream word z
// ---------------------------------------------------------------------------
package snow3g_pkg;

   localparam int INIT_ROUNDS_DEF = 32;
   localparam int KS_WORD_W       = 32;

   // Widest STEP_LAT the step timer supports (1..15 fits a 4-bit counter).
   localparam int STEP_LAT_MAX    = 15;
   localparam int LAT_W           = 4;

   typedef enum logic [2:0] {
      KS_IDLE   = 3'd0,
      KS_LOAD   = 3'd1,
      KS_INIT   = 3'd2,
      KS_DISC   = 3'd3,
      KS_GEN    = 3'd4,
      KS_SETTLE = 3'd5,
      KS_OUT    = 3'd6,
      KS_DONE   = 3'd7
   } ks_state_e;

endpackage

// File: rtl/snow3g_step_timer.sv
// ---------------------------------------------------------------------------
// snow3g_step_timer
// Slot timer for the keystream controller. lat_cnt walks 0..STEP_LAT-1 while
// enabled and wraps, so consecutive slots follow each other without a gap.
// Held at 0 while clr_i is high so every phase starts on a fresh slot.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clr_i   : force lat_cnt to 0
//   en_i    : advance lat_cnt
//   first_o : lat_cnt == 0 (slot start, where a step pulse belongs)
//   last_o  : lat_cnt == STEP_LAT-1 (slot expires at this edge)
// ---------------------------------------------------------------------------
module snow3g_step_timer
   import snow3g_pkg::*;
#(
   parameter int STEP_LAT = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic first_o,
   output logic last_o
);

   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(STEP_LAT - 1);

   logic [LAT_W-1:0] lat_cnt_q;
   logic [LAT_W-1:0] lat_cnt_d;

   assign first_o = (lat_cnt_q == '0);
   assign last_o  = (lat_cnt_q == LAT_LAST);

   always_comb begin
      lat_cnt_d = lat_cnt_q;
      if (clr_i) begin
         lat_cnt_d = '0;
      end else if (en_i) begin
         lat_cnt_d = last_o ? '0 : lat_cnt_q + LAT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lat_cnt_q <= '0;
      end else begin
         lat_cnt_q <= lat_cnt_d;
      end
   end

endmodule

// File: rtl/snow3g_ks_ctrl.sv
// ---------------------------------------------------------------------------
// snow3g_ks_ctrl
// Sequencer for the SNOW 3G keystream datapath: key/IV load, INIT_ROUNDS
// initialisation clockings, one discarded keystream clocking, then len_words
// keystream words presented on a valid/ready interface. Every datapath
// clocking is followed by STEP_LAT cycles before its outputs are trusted.
//
// state  | meaning
// IDLE   | waiting for start; len_words latched on start
// LOAD   | key_load + fsm_clr pulse (one cycle)
// INIT   | INIT_ROUNDS slots, step with init_mode=1 at each slot start
// DISC   | one slot, keystream-mode step whose z is thrown away
// GEN    | one keystream-mode step
// SETTLE | wait STEP_LAT cycles, capture z on the last one
// OUT    | ks_valid held until the consumer takes the word
// DONE   | done pulse, then back to IDLE
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   start_i      : begin a session (IDLE only)
//   len_words_i  : keystream words to produce, latched with start
//   ks_word_in_i : keystream word z from the datapath
//   ks_ready_i   : consumer accepts ks_word_o
//   key_load_o   : load K/IV into the LFSR
//   fsm_clr_o    : clear R1/R2/R3, coincident with key_load_o
//   step_o       : clock LFSR and FSM once
//   init_mode_o  : feed F back into the LFSR on this step
//   ks_word_o    : registered keystream word
//   ks_valid_o   : ks_word_o valid
//   busy_o       : session in progress
//   done_o       : session finished (one cycle)
// ---------------------------------------------------------------------------
module snow3g_ks_ctrl
   import snow3g_pkg::*;
#(
   parameter int INIT_ROUNDS = INIT_ROUNDS_DEF,
   parameter int STEP_LAT    = 1,
   parameter int CNT_W       = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [CNT_W-1:0]     len_words_i,
   input  logic [KS_WORD_W-1:0] ks_word_in_i,
   input  logic                 ks_ready_i,
   output logic                 key_load_o,
   output logic                 fsm_clr_o,
   output logic                 step_o,
   output logic                 init_mode_o,
   output logic [KS_WORD_W-1:0] ks_word_o,
   output logic                 ks_valid_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam logic [2:0] S_IDLE   = KS_IDLE;
   localparam logic [2:0] S_LOAD   = KS_LOAD;
   localparam logic [2:0] S_INIT   = KS_INIT;
   localparam logic [2:0] S_DISC   = KS_DISC;
   localparam logic [2:0] S_GEN    = KS_GEN;
   localparam logic [2:0] S_SETTLE = KS_SETTLE;
   localparam logic [2:0] S_OUT    = KS_OUT;
   localparam logic [2:0] S_DONE   = KS_DONE;

   localparam int               RND_W    = $clog2(INIT_ROUNDS) + 1;
   localparam logic [RND_W-1:0] RND_LAST = RND_W'(INIT_ROUNDS - 1);

   logic [2:0]           state_q,  state_d;
   logic [RND_W-1:0]     rnd_q,    rnd_d;
   logic [CNT_W-1:0]     rem_q,    rem_d;
   logic [KS_WORD_W-1:0] word_q,   word_d;
   logic                 valid_q,  valid_d;

   logic tmr_en;
   logic slot_first;
   logic slot_last;

   // Only the slot-based phases run the timer; elsewhere it is parked at 0
   // so the next slot-based phase always begins at lat_cnt=0.
   assign tmr_en = (state_q == S_INIT) || (state_q == S_DISC) ||
                   (state_q == S_SETTLE);

   snow3g_step_timer #(
      .STEP_LAT (STEP_LAT)
   ) u_step_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (~tmr_en),
      .en_i    (tmr_en),
      .first_o (slot_first),
      .last_o  (slot_last)
   );

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      rem_d   = rem_q;
      word_d  = word_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               rem_d   = len_words_i;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            rnd_d   = '0;
            state_d = S_INIT;
         end
         S_INIT: begin
            if (slot_last) begin
               if (rnd_q == RND_LAST) begin
                  state_d = S_DISC;
               end else begin
                  rnd_d = rnd_q + RND_W'(1);
               end
            end
         end
         S_DISC: begin
            if (slot_last) begin
               state_d = (rem_q == '0) ? S_DONE : S_GEN;
            end
         end
         S_GEN: begin
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (slot_last) begin
               word_d  = ks_word_in_i;
               valid_d = 1'b1;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            // rem_q is never 0 here, so the decrement cannot wrap.
            if (ks_ready_i) begin
               valid_d = 1'b0;
               rem_d   = rem_q - CNT_W'(1);
               state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_GEN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         rnd_q   <= '0;
         rem_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         rem_q   <= rem_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign key_load_o  = (state_q == S_LOAD);
   assign fsm_clr_o   = (state_q == S_LOAD);
   assign step_o      = (((state_q == S_INIT) || (state_q == S_DISC)) && slot_first) ||
                        (state_q == S_GEN);
   assign init_mode_o = (state_q == S_INIT) && slot_first;
   assign ks_word_o   = word_q;
   assign ks_valid_o  = valid_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_snow3g_ks_ctrl.sv
module tb_snow3g_ks_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sel;
   logic        ks_ready;
   logic [15:0] len;
   logic [31:0] ks_in;

   logic        start_a, start_b;
   logic        a_kl, a_fc, a_step, a_im, a_valid, a_busy, a_done;
   logic        b_kl, b_fc, b_step, b_im, b_valid, b_busy, b_done;
   logic [31:0] a_word, b_word;
   logic [6:0]  obs_ctl;
   logic [31:0] obs_word;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign start_a  = start & ~sel;
   assign start_b  = start & sel;
   assign obs_ctl  = sel ? {b_kl, b_fc, b_step, b_im, b_valid, b_busy, b_done}
                         : {a_kl, a_fc, a_step, a_im, a_valid, a_busy, a_done};
   assign obs_word = sel ? b_word : a_word;

   snow3g_ks_ctrl #(.INIT_ROUNDS(32), .STEP_LAT(1), .CNT_W(16)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start_a), .len_words_i(len),
      .ks_word_in_i(ks_in), .ks_ready_i(ks_ready),
      .key_load_o(a_kl), .fsm_clr_o(a_fc), .step_o(a_step), .init_mode_o(a_im),
      .ks_word_o(a_word), .ks_valid_o(a_valid), .busy_o(a_busy), .done_o(a_done));

   snow3g_ks_ctrl #(.INIT_ROUNDS(32), .STEP_LAT(3), .CNT_W(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .len_words_i(len[3:0]),
      .ks_word_in_i(ks_in), .ks_ready_i(ks_ready),
      .key_load_o(b_kl), .fsm_clr_o(b_fc), .step_o(b_step), .init_mode_o(b_im),
      .ks_word_o(b_word), .ks_valid_o(b_valid), .busy_o(b_busy), .done_o(b_done));

   // Reference timeline of one session, cycle 0 = the cycle start is driven.
   // LOAD at 1, INIT slots from 2, DISC slot at 2+32S, words from 2+33S:
   // GEN at g, capture at g+S, valid from g+S+1 until the handshake h,
   // next GEN at h+1; done one cycle after the last handshake.
   // rmode: 0 ready always high, 1 random ready, 2 five-cycle stall on word 1.
   task automatic run_session(input bit s, input int L, input int rmode, input bit poke,
                              output int n_step, output int n_istep, output int n_words,
                              output int n_kl, output int t_done_obs, output int n_bad);
      int S, c, gen_t, left, t_done_exp;
      logic [31:0] cap;
      logic [6:0]  exp_ctl;
      bit exp_step, exp_im, exp_valid, exp_busy;
      S = s ? 3 : 1;
      n_step = 0; n_istep = 0; n_words = 0; n_kl = 0; t_done_obs = -1; n_bad = 0;
      gen_t = 2 + 33 * S;
      left  = L;
      t_done_exp = (L == 0) ? gen_t : -1;
      cap = '0;
      sel = s;
      @(posedge clk); #1;
      c = 0;
      start = 1'b1; len = L[15:0]; ks_in = $urandom; ks_ready = 1'b1;
      forever begin
         @(negedge clk);
         exp_step = 1'b0; exp_im = 1'b0;
         if (c >= 2 && c <= 1 + 32 * S && ((c - 2) % S) == 0) begin
            exp_step = 1'b1; exp_im = 1'b1;
         end
         if (c == 2 + 32 * S) exp_step = 1'b1;
         if (left > 0 && c == gen_t) exp_step = 1'b1;
         exp_valid = (left > 0) && (c > gen_t + S);
         if (left > 0 && c == gen_t + S) cap = ks_in;
         exp_busy = (c >= 1) && (t_done_exp < 0 || c <= t_done_exp);
         exp_ctl = {c == 1, c == 1, exp_step, exp_im, exp_valid, exp_busy, c == t_done_exp};
         if (obs_ctl[4]) n_step++;
         if (obs_ctl[4] && obs_ctl[3]) n_istep++;
         if (obs_ctl[6]) n_kl++;
         if (obs_ctl[2] && ks_ready) n_words++;
         if (obs_ctl[0] && t_done_obs < 0) t_done_obs = c;
         if (obs_ctl !== exp_ctl || (exp_valid && obs_word !== cap)) begin
            n_bad++;
            $display("FAIL trace dut%0d cycle %0d: kl,fc,st,im,vld,bsy,dn=%b word=%h, required %b word=%h",
                     s, c, obs_ctl, obs_word, exp_ctl, cap);
         end
         if (exp_valid && ks_ready) begin
            left--;
            gen_t = c + 1;
            if (left == 0) t_done_exp = c + 1;
         end
         if (t_done_exp >= 0 && c >= t_done_exp + 2) break;
         if (c >= 4000) begin
            n_bad++;
            $display("FAIL session_timeout dut%0d: no done after %0d cycles, required done", s, c);
            break;
         end
         @(posedge clk); #1;
         c++;
         start = poke && ((left > 0 && c == gen_t) || c == t_done_exp);
         ks_in = $urandom;
         case (rmode)
            0:       ks_ready = 1'b1;
            1:       ks_ready = 1'($urandom_range(0, 1));
            default: ks_ready = !(left == L && c <= gen_t + S + 5);
         endcase
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sel = 1'b0; ks_ready = 1'b0; len = '0; ks_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({a_kl, a_fc, a_step, a_im, a_valid, a_busy, a_done, b_kl, b_fc, b_step, b_im, b_valid, b_busy, b_done} !== 14'd0) begin
         failures++;
         $display("FAIL reset_ctl: got a=%b b=%b required all zero",
                  {a_kl, a_fc, a_step, a_im, a_valid, a_busy, a_done},
                  {b_kl, b_fc, b_step, b_im, b_valid, b_busy, b_done});
      end
      checks++;
      if (a_word !== 32'd0 || b_word !== 32'd0) begin
         failures++;
         $display("FAIL reset_word: got a=%h b=%h required 0", a_word, b_word);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int ns, ni, nw, nk, td, nb;
      run_session(1'b0, 2, 0, 1'b0, ns, ni, nw, nk, td, nb);
      checks++; if (nk !== 1)  begin failures++; $display("FAIL basic_key_load: got %0d required 1", nk); end
      checks++; if (ni !== 32) begin failures++; $display("FAIL basic_init_steps: got %0d required 32", ni); end
      checks++; if (ns !== 35) begin failures++; $display("FAIL basic_steps: got %0d required 35", ns); end
      checks++; if (nw !== 2)  begin failures++; $display("FAIL basic_words: got %0d required 2", nw); end
      checks++; if (td !== 41) begin failures++; $display("FAIL basic_done_cycle: got %0d required 41", td); end
      checks++; if (nb !== 0)  begin failures++; $display("FAIL basic_trace: got %0d bad cycles required 0", nb); end
   endtask

   task automatic test_zero_len();
      int ns, ni, nw, nk, td, nb;
      run_session(1'b0, 0, 1, 1'b0, ns, ni, nw, nk, td, nb);
      checks++; if (ns !== 33) begin failures++; $display("FAIL zero_steps: got %0d required 33", ns); end
      checks++; if (nw !== 0)  begin failures++; $display("FAIL zero_words: got %0d required 0", nw); end
      checks++; if (td !== 35) begin failures++; $display("FAIL zero_done_cycle: got %0d required 35", td); end
      checks++; if (nb !== 0)  begin failures++; $display("FAIL zero_trace: got %0d bad cycles required 0", nb); end
   endtask

   task automatic test_backpressure();
      int ns, ni, nw, nk, td, nb;
      run_session(1'b0, 3, 2, 1'b0, ns, ni, nw, nk, td, nb);
      checks++; if (nw !== 3)  begin failures++; $display("FAIL bp_words: got %0d required 3", nw); end
      checks++; if (ns !== 36) begin failures++; $display("FAIL bp_steps: got %0d required 36", ns); end
      checks++; if (td !== 49) begin failures++; $display("FAIL bp_done_cycle: got %0d required 49", td); end
      checks++; if (nb !== 0)  begin failures++; $display("FAIL bp_trace: got %0d bad cycles required 0", nb); end
   endtask

   task automatic test_step_lat3();
      int ns, ni, nw, nk, td, nb;
      run_session(1'b1, 2, 0, 1'b0, ns, ni, nw, nk, td, nb);
      checks++; if (ni !== 32)  begin failures++; $display("FAIL lat3_init_steps: got %0d required 32", ni); end
      checks++; if (td !== 111) begin failures++; $display("FAIL lat3_done_cycle: got %0d required 111", td); end
      checks++; if (nb !== 0)   begin failures++; $display("FAIL lat3_trace: got %0d bad cycles required 0", nb); end
   endtask

   task automatic test_max_len();
      int ns, ni, nw, nk, td, nb;
      run_session(1'b1, 15, 0, 1'b0, ns, ni, nw, nk, td, nb);
      checks++; if (nw !== 15)  begin failures++; $display("FAIL maxlen_words: got %0d required 15", nw); end
      checks++; if (td !== 176) begin failures++; $display("FAIL maxlen_done_cycle: got %0d required 176", td); end
      checks++; if (nb !== 0)   begin failures++; $display("FAIL maxlen_trace: got %0d bad cycles required 0", nb); end
   endtask

   task automatic test_busy_start();
      int ns, ni, nw, nk, td, nb;
      run_session(1'b0, 3, 1, 1'b1, ns, ni, nw, nk, td, nb);
      checks++; if (nw !== 3) begin failures++; $display("FAIL busy_start_words: got %0d required 3", nw); end
      checks++; if (nk !== 1) begin failures++; $display("FAIL busy_start_key_load: got %0d required 1", nk); end
      checks++; if (nb !== 0) begin failures++; $display("FAIL busy_start_trace: got %0d bad cycles required 0", nb); end
   endtask

   task automatic test_random();
      int ns, ni, nw, nk, td, nb, L;
      bit s;
      for (int i = 0; i < 4; i++) begin
         s = 1'($urandom_range(0, 1));
         L = $urandom_range(1, 5);
         run_session(s, L, 1, 1'($urandom_range(0, 1)), ns, ni, nw, nk, td, nb);
         checks++; if (nw !== L)      begin failures++; $display("FAIL rand%0d_words: got %0d required %0d", i, nw, L); end
         checks++; if (ns !== 33 + L) begin failures++; $display("FAIL rand%0d_steps: got %0d required %0d", i, ns, 33 + L); end
         checks++; if (nb !== 0)      begin failures++; $display("FAIL rand%0d_trace: got %0d bad cycles required 0", i, nb); end
      end
   endtask

   task automatic test_reset_mid_init();
      int ns, ni, nw, nk, td, nb;
      sel = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; len = 16'd3;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (c == 10) rst = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b required 1", a_busy); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_kl, a_fc, a_step, a_im, a_valid, a_busy, a_done} !== 7'd0 || a_word !== 32'd0) begin
         failures++;
         $display("FAIL midrst_outputs: got ctl=%b word=%h required 0/0",
                  {a_kl, a_fc, a_step, a_im, a_valid, a_busy, a_done}, a_word);
      end
      run_session(1'b0, 2, 0, 1'b0, ns, ni, nw, nk, td, nb);
      checks++; if (nk !== 1)  begin failures++; $display("FAIL midrst_key_load: got %0d required 1", nk); end
      checks++; if (td !== 41) begin failures++; $display("FAIL midrst_done_cycle: got %0d required 41", td); end
      checks++; if (nb !== 0)  begin failures++; $display("FAIL midrst_trace: got %0d bad cycles required 0", nb); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_backpressure();
      test_step_lat3();
      test_max_len();
      test_busy_start();
      test_random();
      test_reset_mid_init();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
